// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and constants for the Nios II OCI data-capture-trace buffer.
package nios2_oci_dct_pkg;

  localparam int unsigned DATA_W    = 30;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MODE_STOP = 0;
  localparam int unsigned MODE_WRAP = 1;

  typedef enum logic [1:0] {
    StCapture,
    StEnding,
    StDone
  } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_capture_if.sv
// Capture-side and drain-side signals of the DCT buffer; master drives, slave is the buffer.
interface nios2_oci_dct_capture_if #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              dct_valid;
  logic [DATA_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_ending;
  logic              test_has_ended;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  rd_count;
  logic [LVL_W-1:0]  level;
  logic [DROP_W-1:0] drop_cnt;
  logic              ending;
  logic              done;

  modport master (
    output dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_ready,
    input  rd_valid, rd_data, rd_count, level, drop_cnt, ending, done
  );

  modport slave (
    input  dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_ready,
    output rd_valid, rd_data, rd_count, level, drop_cnt, ending, done
  );

endinterface

// File: rtl/nios2_oci_dct_ram.sv
// Register-array storage: one synchronous write port, combinational read.
module nios2_oci_dct_ram #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// DCT ring buffer: captures trace words, stops or wraps when full, counts losses,
// and freezes capture on test end so the host can drain before done is raised.
module nios2_oci_dct_capture #(
  parameter int unsigned DATA_W    = nios2_oci_dct_pkg::DATA_W,
  parameter int unsigned CNT_W     = nios2_oci_dct_pkg::CNT_W,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WRAP_MODE = nios2_oci_dct_pkg::MODE_STOP,
  parameter int unsigned DROP_W    = 8
) (
  input logic                   clk,
  input logic                   reset,
  nios2_oci_dct_capture_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WORD_W = CNT_W + DATA_W;
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  nios2_oci_dct_pkg::dct_state_e state_q, state_d;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DROP_W-1:0] drop_q;
  logic [WORD_W-1:0] rd_word;
  logic              empty, full, wr_req, rd_fire;
  logic              wr_en, overwrite, drop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign wr_req  = bus.dct_valid && (state_q == nios2_oci_dct_pkg::StCapture);
  assign rd_fire = !empty && bus.rd_ready;

  // A same-cycle read always makes room, so only a lone write to a full buffer is lost.
  always_comb begin
    wr_en     = 1'b0;
    overwrite = 1'b0;
    drop      = 1'b0;
    if (wr_req) begin
      if (!full || rd_fire) begin
        wr_en = 1'b1;
      end else if (WRAP_MODE == nios2_oci_dct_pkg::MODE_WRAP) begin
        wr_en     = 1'b1;
        overwrite = 1'b1;
        drop      = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (wr_en && !rd_fire && !overwrite) begin
      level_d = level_q + 1'b1;
    end else if (rd_fire && !wr_en) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_fire || overwrite) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      if (drop && (drop_q != DROP_MAX)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  nios2_oci_dct_ram #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata({bus.dct_count, bus.dct_buffer}),
    .raddr(rd_ptr_q),
    .rdata(rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= nios2_oci_dct_pkg::StCapture;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      nios2_oci_dct_pkg::StCapture: begin
        if (bus.test_ending) begin
          state_d = nios2_oci_dct_pkg::StEnding;
        end
      end
      nios2_oci_dct_pkg::StEnding: begin
        if (empty && bus.test_has_ended && !rd_fire) begin
          state_d = nios2_oci_dct_pkg::StDone;
        end
      end
      nios2_oci_dct_pkg::StDone: state_d = nios2_oci_dct_pkg::StDone;
      default: state_d = nios2_oci_dct_pkg::StCapture;
    endcase
  end

  // Stale memory is masked so the read port shows zeros whenever the buffer is empty.
  always_comb begin
    bus.rd_valid = !empty;
    bus.rd_data  = empty ? '0 : rd_word[DATA_W-1:0];
    bus.rd_count = empty ? '0 : rd_word[WORD_W-1:DATA_W];
    bus.level    = level_q;
    bus.drop_cnt = drop_q;
    bus.ending   = (state_q != nios2_oci_dct_pkg::StCapture);
    bus.done     = (state_q == nios2_oci_dct_pkg::StDone);
  end

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Scoreboard bench: a stop-mode and a wrap-mode buffer share one stimulus stream.
module tb_nios2_oci_dct_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        rd_ready;

  int checks   = 0;
  int failures = 0;

  logic [33:0] q_s[$];
  logic [33:0] q_w[$];

  always #5 clk = ~clk;

  nios2_oci_dct_capture_if #(.DATA_W(30), .CNT_W(4), .DEPTH(16), .DROP_W(8)) bus_s ();
  nios2_oci_dct_capture_if #(.DATA_W(30), .CNT_W(4), .DEPTH(16), .DROP_W(8)) bus_w ();

  assign bus_s.dct_valid      = dct_valid;
  assign bus_s.dct_buffer     = dct_buffer;
  assign bus_s.dct_count      = dct_count;
  assign bus_s.test_ending    = test_ending;
  assign bus_s.test_has_ended = test_has_ended;
  assign bus_s.rd_ready       = rd_ready;
  assign bus_w.dct_valid      = dct_valid;
  assign bus_w.dct_buffer     = dct_buffer;
  assign bus_w.dct_count      = dct_count;
  assign bus_w.test_ending    = test_ending;
  assign bus_w.test_has_ended = test_has_ended;
  assign bus_w.rd_ready       = rd_ready;

  nios2_oci_dct_capture #(
    .DATA_W(30), .CNT_W(4), .DEPTH(16), .WRAP_MODE(0), .DROP_W(8)
  ) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_s)
  );

  nios2_oci_dct_capture #(
    .DATA_W(30), .CNT_W(4), .DEPTH(16), .WRAP_MODE(1), .DROP_W(8)
  ) dut_w (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_w)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read transfers complete at the next posedge, so sample them on the negedge.
  always @(negedge clk) begin
    if (!reset && bus_s.rd_valid && rd_ready) begin
      if (q_s.size() == 0) chk("stop_rd_unexpected", {bus_s.rd_count, bus_s.rd_data}, 64'hdead);
      else chk("stop_rd", {bus_s.rd_count, bus_s.rd_data}, q_s.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && bus_w.rd_valid && rd_ready) begin
      if (q_w.size() == 0) chk("wrap_rd_unexpected", {bus_w.rd_count, bus_w.rd_data}, 64'hdead);
      else chk("wrap_rd", {bus_w.rd_count, bus_w.rd_data}, q_w.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [29:0] d, input logic [3:0] c, input bit es, input bit ew);
    dct_valid  = 1'b1;
    dct_buffer = d;
    dct_count  = c;
    if (es) q_s.push_back({c, d});
    if (ew) q_w.push_back({c, d});
    tick();
    dct_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    while ((q_s.size() != 0 || q_w.size() != 0) && n < 64) begin
      tick();
      n++;
    end
    rd_ready = 1'b0;
    chk("drain_timeout", 64'(n >= 64), 64'd0);
  endtask

  task automatic chk_both(input string name, input logic [63:0] s, input logic [63:0] w,
                          input logic [63:0] exp);
    chk({"stop_", name}, s, exp);
    chk({"wrap_", name}, w, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_both({tag, "_rd_valid"}, bus_s.rd_valid, bus_w.rd_valid, 0);
    chk_both({tag, "_rd_data"}, bus_s.rd_data, bus_w.rd_data, 0);
    chk_both({tag, "_rd_count"}, bus_s.rd_count, bus_w.rd_count, 0);
    chk_both({tag, "_level"}, bus_s.level, bus_w.level, 0);
    chk_both({tag, "_drop"}, bus_s.drop_cnt, bus_w.drop_cnt, 0);
    chk_both({tag, "_ending"}, bus_s.ending, bus_w.ending, 0);
    chk_both({tag, "_done"}, bus_s.done, bus_w.done, 0);
  endtask

  initial begin
    reset          = 1'b1;
    dct_valid      = 1'b0;
    dct_buffer     = '0;
    dct_count      = '0;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    rd_ready       = 1'b0;
    tick();
    tick();
    chk_reset_vals("init");
    reset = 1'b0;
    tick();

    // Basic FIFO: five words in, then drained in order.
    for (int i = 1; i <= 5; i++) put(30'(i), 4'(i), 1'b1, 1'b1);
    chk_both("basic_level", bus_s.level, bus_w.level, 5);
    chk_both("basic_rd_valid", bus_s.rd_valid, bus_w.rd_valid, 1);
    drain();
    chk_both("basic_level_end", bus_s.level, bus_w.level, 0);
    chk_both("basic_drop", bus_s.drop_cnt, bus_w.drop_cnt, 0);

    // Twenty writes into sixteen slots: stop keeps 1..16, wrap keeps 5..20.
    for (int i = 1; i <= 20; i++) put(30'(i), 4'(i), i <= 16, i >= 5);
    chk_both("over_level", bus_s.level, bus_w.level, 16);
    chk_both("over_drop", bus_s.drop_cnt, bus_w.drop_cnt, 4);
    drain();
    chk_both("over_level_end", bus_s.level, bus_w.level, 0);

    // Full with a simultaneous read and write: accepted, no new drop.
    for (int i = 1; i <= 16; i++) put(30'h100 + 30'(i), 4'(i), 1'b1, 1'b1);
    rd_ready = 1'b1;
    put(30'h200, 4'ha, 1'b1, 1'b1);
    rd_ready = 1'b0;
    chk_both("rw_full_level", bus_s.level, bus_w.level, 16);
    chk_both("rw_full_drop", bus_s.drop_cnt, bus_w.drop_cnt, 4);
    drain();

    // Mid-run asynchronous reset with level 7 and two drops outstanding.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 18; i++)
      put(30'h300 + 30'(i), 4'(i), i <= 9, (i >= 3) && (i <= 11));
    rd_ready = 1'b1;
    repeat (9) tick();
    rd_ready = 1'b0;
    chk_both("pre_rst_level", bus_s.level, bus_w.level, 7);
    chk_both("pre_rst_drop", bus_s.drop_cnt, bus_w.drop_cnt, 2);
    #3 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    tick();
    reset = 1'b0;
    tick();

    // Ending: the word sampled with test_ending is kept, later words are ignored.
    for (int i = 1; i <= 3; i++) put(30'h400 + 30'(i), 4'(i), 1'b1, 1'b1);
    test_ending = 1'b1;
    put(30'h404, 4'h4, 1'b1, 1'b1);
    for (int i = 5; i <= 7; i++) put(30'h400 + 30'(i), 4'(i), 1'b0, 1'b0);
    chk_both("end_ending", bus_s.ending, bus_w.ending, 1);
    chk_both("end_level", bus_s.level, bus_w.level, 4);
    chk_both("end_drop", bus_s.drop_cnt, bus_w.drop_cnt, 0);
    chk_both("end_done_early", bus_s.done, bus_w.done, 0);
    test_has_ended = 1'b1;
    drain();
    chk_both("end_level_drained", bus_s.level, bus_w.level, 0);
    chk_both("end_done_same", bus_s.done, bus_w.done, 0);
    tick();
    chk_both("end_done", bus_s.done, bus_w.done, 1);
    chk_both("end_ending_held", bus_s.ending, bus_w.ending, 1);
    chk_both("end_rd_valid", bus_s.rd_valid, bus_w.rd_valid, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios2_oci_dct_capture.md
# nios2_oci_dct_capture

Parametrised data-capture-trace (DCT) buffer for the Nios II on-chip instrumentation (OCI) simulation environment. It accepts DCT words with their fragment counts from the OCI trace path into a ring buffer. It stops or wraps on full according to a mode parameter and counts lost words. It also runs the test-ending sequence, so a bench or debug host can drain every captured word before the run is declared done.

## Interface
Parameters:
- DATA_W, 30, width of dct_buffer word
- CNT_W, 4, width of dct_count
- DEPTH, 16, buffer entries; power of two, >= 2
- WRAP_MODE, 0, 0 = stop-on-full (drop new), 1 = wrap (overwrite oldest)
- DROP_W, 8, width of saturating drop counter

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  capture clock
- reset  in  1  asynchronous, active-high reset
- dct_valid  in  1  dct_buffer/dct_count valid this cycle
- dct_buffer  in  DATA_W  trace data word
- dct_count  in  CNT_W  fragment count for this word
- test_ending  in  1  level; the test is finishing, stop capture
- test_has_ended  in  1  level; the producer has fully quiesced
- rd_ready  in  1  consumer accepts rd_data
- rd_valid  out  1  buffer non-empty, rd_data valid
- rd_data  out  DATA_W  oldest stored word
- rd_count  out  CNT_W  count stored with rd_data
- level  out  clog2(DEPTH)+1  current occupancy
- drop_cnt  out  DROP_W  words lost, saturating
- ending  out  1  capture frozen (state ENDING or DONE)
- done  out  1  sticky; drain complete

## Operation
- States: CAPTURE, ENDING, DONE.
- CAPTURE: each dct_valid cycle stores {dct_count, dct_buffer} at wr_ptr.
- CAPTURE -> ENDING: on the first cycle test_ending is sampled high. A dct_valid word in that same cycle is still stored. From the next cycle dct_valid is ignored and not counted as dropped.
- ENDING -> DONE: when level == 0, test_has_ended == 1, and no read is accepted in that cycle.
- DONE: terminal until reset. Further reads are impossible because the buffer is empty.
- Read: a transfer occurs when rd_valid && rd_ready; rd_ptr advances. The read path is first-word-fall-through: rd_data and rd_count come from mem[rd_ptr].
- Full, stop mode (WRAP_MODE = 0): a write with no same-cycle read is dropped and drop_cnt increments. A write with a same-cycle read is accepted and level is unchanged.
- Full, wrap mode (WRAP_MODE = 1): a write with no same-cycle read overwrites the oldest entry. wr_ptr and rd_ptr both advance, level stays DEPTH, and drop_cnt increments. A write with a same-cycle read is a normal push/pop, with no drop.
- Empty with a simultaneous write: the read is not possible (rd_valid = 0), so the write is stored.
- drop_cnt saturates at 2^DROP_W - 1.
- Pointers are clog2(DEPTH) bits wide and wrap naturally. level is computed as an explicit counter: +1 on write-only, -1 on read-only, unchanged otherwise.

## Timing
- Reset values: rd_valid 0, rd_data and rd_count 0 (mem contents don't-care, but outputs are forced to 0 while empty), level 0, drop_cnt 0, ending 0, done 0, state CAPTURE, pointers 0.
- Write-to-read latency: a word written at edge N gives rd_valid high after edge N and is readable in cycle N+1.
- level, drop_cnt, ending and done are registered and update on the edge following the event.
- done rises one cycle after the ENDING -> DONE condition holds.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Buffer contents are discarded.

## Structure
- Package nios2_oci_dct_pkg holds:
  - state enum (CAPTURE, ENDING, DONE)
  - mode constants MODE_STOP = 0 and MODE_WRAP = 1
  - default widths DATA_W = 30 and CNT_W = 4
- Sub-module nios2_oci_dct_ram is the register-array storage, DEPTH x (CNT_W + DATA_W). It has one synchronous write port and a combinational read address.
- Pointer, level, drop and FSM logic live in the top module.

## Test plan
- Basic FIFO, DEPTH = 16: write 5 words (data 0x1..0x5, count 1..5), then read with rd_ready = 1 -> words return in order, level returns 5 -> 0, drop_cnt = 0.
- Stop mode: write 20 words with no reads -> level = 16, drop_cnt = 4, reads return words 1..16.
- Wrap mode: write 20 words with no reads -> level = 16, drop_cnt = 4, reads return words 5..20.
- Full plus simultaneous read/write in stop mode -> write accepted, level stays 16, drop_cnt unchanged.
- Ending sequence: 3 words stored, then test_ending = 1 together with a 4th word, then dct_valid continues -> only 4 words stored, ending = 1. Drain all 4 with test_has_ended = 1 -> done = 1 one cycle after the last read.
- Reset mid-run: level = 7 and drop_cnt = 2 at the moment reset asserts -> all outputs return to reset values the same cycle.
